// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with prescaled count tick and a multiplexed digit scan.
// Optional build macro BLANK_LEADING_ZEROS_EN: leading-zero digits (except digit 0) are scanned out as 4'hF.
module bcd_counter_scan #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  output logic [4*NDIG-1:0]   count,
  output logic                carry,
  output logic [3:0]          digit,
  output logic [NDIG-1:0]     sel
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [PW-1:0]     pre;
  logic [SW-1:0]     scnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              scan_term;
  logic [4*NDIG-1:0] load_clean;
  logic [4*NDIG-1:0] step_val;
  logic              wrap;
  logic              cin;
  logic [3:0]        nib;
  logic [3:0]        digit_nxt;
`ifdef BLANK_LEADING_ZEROS_EN
  logic              blank;
`endif

  assign tick      = en && (pre == PW'(TICK_DIV - 1));
  assign scan_term = (scnt == SW'(SCAN_DIV - 1));

  // Ripple increment/decrement across all digits; wrap is the carry/borrow out of the top digit.
  always_comb begin
    load_clean = '0;
    step_val   = count;
    cin        = 1'b1;
    nib        = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
      nib = count[4*i +: 4];
      if (cin) begin
        if (up) begin
          if (nib == 4'd9) nib = 4'd0;
          else begin
            nib = nib + 4'd1;
            cin = 1'b0;
          end
        end else begin
          if (nib == 4'd0) nib = 4'd9;
          else begin
            nib = nib - 4'd1;
            cin = 1'b0;
          end
        end
      end
      step_val[4*i +: 4] = nib;
    end
    wrap = cin;
  end

  always_comb begin
`ifdef BLANK_LEADING_ZEROS_EN
    blank = (idx != '0);
    for (int unsigned j = 0; j < NDIG; j++) begin
      if (j >= 32'(idx) && count[4*j +: 4] != 4'd0) blank = 1'b0;
    end
    digit_nxt = blank ? 4'hF : count[4*idx +: 4];
`else
    digit_nxt = count[4*idx +: 4];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      carry <= 1'b0;
      digit <= '0;
      sel   <= '1;
      pre   <= '0;
      scnt  <= '0;
      idx   <= '0;
    end else begin
      carry <= 1'b0;
      if (load) begin
        count <= load_clean;
        pre   <= '0;
      end else begin
        if (en) pre <= tick ? '0 : pre + PW'(1);
        if (tick) begin
          count <= step_val;
          carry <= wrap;
        end
      end

      if (scan_term) begin
        scnt <= '0;
        idx  <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      end else begin
        scnt <= scnt + SW'(1);
      end

      sel   <= ~(NDIG'(1) << idx);
      digit <= digit_nxt;
    end
  end

endmodule
